// File: rtl/cpu_clk_ctrl_if.sv
// Control/status bundle between a host (board glue or testbench) and the
// 6502 clock/reset/run-control generator.
interface cpu_clk_ctrl_if #(
  parameter int DIV_W = 24,
  parameter int CNT_W = 32
);
  // host -> generator
  logic [DIV_W-1:0] div_half;
  logic             run_en;
  logic             halt_req;
  logic             step_req;
  logic [CNT_W-1:0] limit;
  logic [1:0]       led_sel;
  logic [7:0]       src0;
  logic [7:0]       src1;
  logic [7:0]       src2;
  logic [7:0]       src3;

  // generator -> host / CPU
  logic             cpu_clk;
  logic             cpu_res;
  logic             cpu_rise;
  logic [CNT_W-1:0] cyc_count;
  logic [2:0]       state;
  logic             done;
  logic [7:0]       led;

  modport master (
    output div_half, run_en, halt_req, step_req, limit, led_sel,
           src0, src1, src2, src3,
    input  cpu_clk, cpu_res, cpu_rise, cyc_count, state, done, led
  );

  modport slave (
    input  div_half, run_en, halt_req, step_req, limit, led_sel,
           src0, src1, src2, src3,
    output cpu_clk, cpu_res, cpu_rise, cyc_count, state, done, led
  );
endinterface

// File: rtl/cpu_clk_ctrl.sv
// Clock, reset and run-control generator for the 6502 core.
// Derives cpu_clk from CLK with a programmable half-period, holds the CPU in
// reset for RES_CYC CPU cycles after a start delay, then free-runs, runs to a
// cycle limit or single-steps. Also provides a registered debug LED mux.
module cpu_clk_ctrl #(
  parameter int DIV_W     = 24,
  parameter int CNT_W     = 32,
  parameter int START_DLY = 100,
  parameter int RES_CYC   = 2
) (
  input  logic          CLK,
  input  logic          R,
  cpu_clk_ctrl_if.slave bus
);

  localparam int WAIT_W = (START_DLY > 0) ? $clog2(START_DLY + 1) : 1;
  localparam int RES_W  = $clog2(RES_CYC + 1);

  typedef enum logic [2:0] {
    S_WAIT = 3'd0,
    S_RUN  = 3'd1,
    S_HALT = 3'd2,
    S_STEP = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WAIT_W-1:0]   r_wait;
  logic [DIV_W-1:0]    r_div;
  logic [DIV_W-1:0]    r_half;
  logic                r_cpu_clk;
  logic                r_cpu_rise;
  logic [RES_W-1:0]    r_res_cnt;
  logic                r_cpu_res;
  logic [CNT_W-1:0]    r_cyc;
  logic [7:0]          r_led;

  logic                w_running;
  logic                w_done;
  logic                w_tick;
  logic                w_rise;
  logic                w_fall;
  logic                w_lim;
  logic                w_wait_end;

  // A toggle happens when the divider counter reaches the latched half-period.
  assign w_tick     = w_running && (r_div == r_half);
  assign w_rise     = w_tick && !r_cpu_clk;
  assign w_fall     = w_tick && r_cpu_clk;
  assign w_lim      = (bus.limit != '0) && (r_cyc == bus.limit);
  assign w_wait_end = (r_wait == WAIT_W'(START_DLY - 1));

  // State register.
  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      r_state <= S_WAIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; RUN/STEP only leave on a falling toggle so cpu_clk is
  // always low in HALT and DONE.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_WAIT: begin
        if (w_wait_end) begin
          w_state_nxt = bus.run_en ? S_RUN : S_HALT;
        end
      end
      S_RUN: begin
        if (w_fall) begin
          if (w_lim) begin
            w_state_nxt = S_DONE;
          end else if (bus.halt_req || !bus.run_en) begin
            w_state_nxt = S_HALT;
          end
        end
      end
      S_HALT: begin
        if (bus.run_en && !bus.halt_req) begin
          w_state_nxt = S_RUN;
        end else if (bus.step_req) begin
          w_state_nxt = S_STEP;
        end
      end
      S_STEP: begin
        if (w_fall) begin
          w_state_nxt = w_lim ? S_DONE : S_HALT;
        end
      end
      S_DONE: begin
        w_state_nxt = S_DONE;
      end
      default: begin
        w_state_nxt = S_WAIT;
      end
    endcase
  end

  // State-decoded outputs: divider enable and done flag.
  always_comb begin
    w_running = (r_state == S_RUN) || (r_state == S_STEP);
    w_done    = (r_state == S_DONE);
  end

  // Start-delay counter, only advances in WAIT.
  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      r_wait <= '0;
    end else if (r_state == S_WAIT) begin
      r_wait <= r_wait + WAIT_W'(1);
    end
  end

  // Divider and cpu_clk. The half-period is re-sampled at every reload and
  // continuously while idle, so a restart from HALT uses the current value.
  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      r_div      <= '0;
      r_half     <= '0;
      r_cpu_clk  <= 1'b0;
      r_cpu_rise <= 1'b0;
    end else begin
      r_cpu_rise <= w_rise;
      if (w_tick) begin
        r_div     <= '0;
        r_half    <= bus.div_half;
        r_cpu_clk <= !r_cpu_clk;
      end else if (w_running) begin
        r_div <= r_div + DIV_W'(1);
      end else if (r_state != S_DONE) begin
        r_div  <= '0;
        r_half <= bus.div_half;
      end
    end
  end

  // CPU reset sequencing: count rises under reset, release on the fall that
  // closes the last reset cycle.
  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      r_res_cnt <= '0;
      r_cpu_res <= 1'b1;
    end else if (r_cpu_res) begin
      if (w_rise) begin
        r_res_cnt <= r_res_cnt + RES_W'(1);
      end
      if (w_fall && (r_res_cnt == RES_W'(RES_CYC))) begin
        r_cpu_res <= 1'b0;
      end
    end
  end

  // CPU cycle counter, counts rises once the CPU is out of reset.
  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      r_cyc <= '0;
    end else if (w_rise && !r_cpu_res) begin
      r_cyc <= r_cyc + CNT_W'(1);
    end
  end

  // Registered debug LED mux, independent of the run state.
  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      r_led <= 8'h00;
    end else begin
      unique case (bus.led_sel)
        2'd0:    r_led <= bus.src0;
        2'd1:    r_led <= bus.src1;
        2'd2:    r_led <= bus.src2;
        default: r_led <= bus.src3;
      endcase
    end
  end

  assign bus.cpu_clk   = r_cpu_clk;
  assign bus.cpu_res   = r_cpu_res;
  assign bus.cpu_rise  = r_cpu_rise;
  assign bus.cyc_count = r_cyc;
  assign bus.state     = r_state;
  assign bus.done      = w_done;
  assign bus.led       = r_led;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Bench for cpu_clk_ctrl: phase-timer reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_cpu_clk_ctrl;
  localparam int DIV_W     = 24;
  localparam int CNT_W     = 32;
  localparam int START_DLY = 100;
  localparam int RES_CYC   = 2;

  logic CLK = 1'b0;
  logic R   = 1'b0;
  int   errors = 0;
  int   checks = 0;
  bit   cmp_en = 0;

  cpu_clk_ctrl_if #(.DIV_W(DIV_W), .CNT_W(CNT_W)) bus ();

  cpu_clk_ctrl #(
    .DIV_W(DIV_W), .CNT_W(CNT_W), .START_DLY(START_DLY), .RES_CYC(RES_CYC)
  ) u_dut (
    .CLK(CLK),
    .R  (R),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  // Reference model: state code, cycles left in current phase, total rises.
  int              m_state = 0;
  int              m_t     = 0;
  int              m_left  = 0;
  bit              m_clk   = 0;
  bit              m_rise  = 0;
  longint unsigned m_rises = 0;
  logic [7:0]      m_led   = 8'h00;

  function automatic logic [31:0] cyc_of(longint unsigned r);
    return (r > longint'(RES_CYC)) ? 32'(r - longint'(RES_CYC)) : 32'd0;
  endfunction

  function automatic bit res_of(longint unsigned r, bit ck);
    return (r < longint'(RES_CYC)) || ((r == longint'(RES_CYC)) && ck);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge CLK or negedge R) begin : model
    int              st;
    int              t;
    int              lft;
    bit              ck;
    bit              rz;
    longint unsigned rs;
    if (!R) begin
      m_state <= 0;
      m_t     <= 0;
      m_left  <= 0;
      m_clk   <= 0;
      m_rise  <= 0;
      m_rises <= 0;
      m_led   <= 8'h00;
    end else begin
      st = m_state; t = m_t; lft = m_left; ck = m_clk; rs = m_rises; rz = 0;
      case (st)
        0: begin
          t++;
          if (t == START_DLY) begin
            st  = bus.run_en ? 1 : 2;
            lft = int'(bus.div_half) + 1;
          end
        end
        1, 3: begin
          lft--;
          if (lft == 0) begin
            lft = int'(bus.div_half) + 1;
            if (!ck) begin
              ck = 1; rs++; rz = 1;
            end else begin
              ck = 0;
              if (bus.limit != 0 && cyc_of(rs) == bus.limit) st = 4;
              else if (st == 3 || bus.halt_req || !bus.run_en) st = 2;
            end
          end
        end
        2: begin
          if (bus.run_en && !bus.halt_req) begin
            st = 1; lft = int'(bus.div_half) + 1;
          end else if (bus.step_req) begin
            st = 3; lft = int'(bus.div_half) + 1;
          end
        end
        default: ;
      endcase
      m_state <= st;
      m_t     <= t;
      m_left  <= lft;
      m_clk   <= ck;
      m_rise  <= rz;
      m_rises <= rs;
      case (bus.led_sel)
        2'd0:    m_led <= bus.src0;
        2'd1:    m_led <= bus.src1;
        2'd2:    m_led <= bus.src2;
        default: m_led <= bus.src3;
      endcase
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    if (cmp_en) begin
      chk("cpu_clk",   bus.cpu_clk,   m_clk);
      chk("cpu_res",   bus.cpu_res,   res_of(m_rises, m_clk));
      chk("cpu_rise",  bus.cpu_rise,  m_rise);
      chk("cyc_count", bus.cyc_count, cyc_of(m_rises));
      chk("state",     bus.state,     m_state);
      chk("done",      bus.done,      m_state == 4);
      chk("led",       bus.led,       m_led);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    R = 1'b0;
    tick();
    tick();
    R = 1'b1;
  endtask

  task automatic wait_rise(input int budget, input string name);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!bus.cpu_rise && n < budget);
    chk(name, bus.cpu_rise, 1'b1);
  endtask

  task automatic wait_state(input int s, input int budget, input string name);
    int n = 0;
    do begin
      tick();
      n++;
    end while (int'(bus.state) != s && n < budget);
    chk(name, bus.state, s);
  endtask

  task automatic run_len(input logic lvl, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.cpu_clk == lvl && n < 200);
  endtask

  task automatic first_rise(input string name);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!bus.cpu_clk && n < 300);
    chk(name, n, 101);
  endtask

  logic [7:0] exp_led [4];

  initial begin
    int n, rises, prev, gap, tog;
    exp_led = '{8'h11, 8'h22, 8'h44, 8'h88};
    bus.div_half = '0; bus.run_en = 1'b1; bus.halt_req = 1'b0; bus.step_req = 1'b0;
    bus.limit = '0; bus.led_sel = 2'd0;
    bus.src0 = 8'h11; bus.src1 = 8'h22; bus.src2 = 8'h44; bus.src3 = 8'h88;
    tick();
    tick();
    cmp_en = 1;
    chk("rst_cpu_clk", bus.cpu_clk, 1'b0);
    chk("rst_cpu_res", bus.cpu_res, 1'b1);
    chk("rst_state",   bus.state, 3'd0);
    chk("rst_led",     bus.led, 8'h00);

    // Reset release: first rise 101 CLK after release, two reset cycles.
    R = 1'b1;
    first_rise("first_rise_cycle");
    chk("res_rise1", bus.cpu_res, 1'b1);
    wait_rise(10, "rise2_timeout");
    chk("res_rise2", bus.cpu_res, 1'b1);
    chk("cyc_rise2", bus.cyc_count, 32'd0);
    run_len(1'b1, n);
    chk("res_released", bus.cpu_res, 1'b0);
    wait_rise(10, "rise3_timeout");
    chk("cyc_rise3", bus.cyc_count, 32'd1);

    // Limited run: 5 counted rises of period 8, then frozen in DONE.
    bus.div_half = 24'd3; bus.limit = 32'd5;
    do_reset();
    n = 0; rises = 0; prev = 0; gap = 0;
    do begin
      tick();
      n++;
      if (bus.cpu_rise) begin
        rises++; gap = n - prev; prev = n;
      end
    end while (bus.state != 3'd4 && n < 2000);
    chk("lim_state", bus.state, 3'd4);
    chk("lim_rises", rises, RES_CYC + 5);
    chk("lim_period", gap, 8);
    chk("lim_cyc", bus.cyc_count, 32'd5);
    chk("lim_done", bus.done, 1'b1);
    chk("lim_clk", bus.cpu_clk, 1'b0);
    tog = 0;
    repeat (1000) begin
      tick();
      if (bus.cpu_rise || bus.cpu_clk) tog++;
    end
    chk("lim_frozen", tog, 0);
    bus.limit = '0;

    // Halt mid high phase, then three single steps.
    do_reset();
    n = 0;
    do begin
      tick();
      n++;
    end while (!(bus.cpu_rise && bus.cyc_count == 32'd3) && n < 500);
    chk("halt_pre_clk", bus.cpu_clk, 1'b1);
    bus.halt_req = 1'b1;
    wait_state(2, 50, "halt_state");
    chk("halt_clk", bus.cpu_clk, 1'b0);
    chk("halt_cyc", bus.cyc_count, 32'd3);
    for (int i = 0; i < 3; i++) begin
      bus.step_req = 1'b1;
      tick();
      bus.step_req = 1'b0;
      chk("step_enter", bus.state, 3'd3);
      wait_state(2, 50, "step_back_halt");
    end
    chk("step_cyc", bus.cyc_count, 32'd6);
    bus.halt_req = 1'b0;

    // Half-period change mid-run takes effect after the current phase.
    bus.div_half = 24'd1;
    do_reset();
    wait_rise(300, "div_rise_timeout");
    bus.div_half = 24'd4;
    run_len(1'b1, n);
    chk("div_old_phase", n, 2);
    run_len(1'b0, n);
    chk("div_new_low", n, 5);
    run_len(1'b1, n);
    chk("div_new_high", n, 5);

    // Asynchronous reset while stepping with cpu_clk high.
    bus.run_en = 1'b0; bus.div_half = 24'd5; bus.led_sel = 2'd2;
    do_reset();
    wait_state(2, 200, "step_halt_state");
    bus.step_req = 1'b1;
    tick();
    bus.step_req = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.cpu_clk && n < 50);
    chk("step_high", bus.cpu_clk, 1'b1);
    #3;
    R = 1'b0;
    #1;
    chk("ar_cpu_clk",  bus.cpu_clk, 1'b0);
    chk("ar_cpu_res",  bus.cpu_res, 1'b1);
    chk("ar_cpu_rise", bus.cpu_rise, 1'b0);
    chk("ar_cyc",      bus.cyc_count, 32'd0);
    chk("ar_state",    bus.state, 3'd0);
    chk("ar_done",     bus.done, 1'b0);
    chk("ar_led",      bus.led, 8'h00);
    tick();
    bus.div_half = '0; bus.run_en = 1'b1;
    R = 1'b1;
    first_rise("rerun_first_rise");

    // LED mux latency.
    for (int k = 0; k < 4; k++) begin
      bus.led_sel = 2'(k);
      tick();
      chk("led_sel", bus.led, exp_led[k]);
    end

    // Randomized traffic, checked by the per-cycle comparison.
    for (int seg = 0; seg < 5; seg++) begin
      bus.div_half = 24'($urandom_range(0, 3));
      bus.limit    = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'($urandom_range(10, 30));
      bus.run_en   = 1'($urandom_range(0, 1));
      bus.halt_req = 1'b0;
      do_reset();
      repeat (800) begin
        if ($urandom_range(0, 19) == 0) bus.run_en = !bus.run_en;
        if ($urandom_range(0, 19) == 0) bus.halt_req = !bus.halt_req;
        bus.step_req = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 49) == 0) bus.div_half = 24'($urandom_range(0, 3));
        bus.led_sel = 2'($urandom_range(0, 3));
        bus.src0 = 8'($urandom); bus.src1 = 8'($urandom);
        bus.src2 = 8'($urandom); bus.src3 = 8'($urandom);
        if ($urandom_range(0, 999) == 0) begin
          #2; R = 1'b0; #1; R = 1'b1;
        end
        tick();
      end
    end
    bus.step_req = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
